// File: rtl/decoder_38_seq.sv
// decoder_38_seq: registered 3-to-8 decoder that turns the code word of a
// priority encoder (Y/GS/EO) into a one-hot pulse held for HOLD_CYCLES cycles.
// Side outputs: a sticky bitmap of decoded indices (pend), a saturating count
// of "enabled but no request" words (empty_cnt) and a sticky illegal-word
// flag (err).
module decoder_38_seq #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EI,
  input  logic       in_valid,
  input  logic [2:0] Y,
  input  logic       GS,
  input  logic       EO,
  input  logic [7:0] clr,
  output logic       in_ready,
  output logic [7:0] O,
  output logic       O_valid,
  output logic [7:0] pend,
  output logic [7:0] empty_cnt,
  output logic       err
);

  // Reject out-of-range hold lengths at elaboration time.
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("decoder_38_seq: HOLD_CYCLES must be in 1..255");
  end

  // hold_cnt counts the cycles remaining after the current one, so the
  // load value is one less than the number of cycles O stays high.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [7:0] hold_cnt, hold_cnt_n;
  logic [7:0] o_n;
  logic       o_valid_n;
  logic [7:0] pend_n;
  logic [7:0] empty_cnt_n;
  logic       err_n;

  // Word classification.
  logic       accept;
  logic       word_legal;
  logic       word_empty;
  logic       word_illegal;
  logic [7:0] decoded;
  logic [7:0] set_vec;

  // Handshake: only an enabled, idle, out-of-reset block takes a word.
  always_comb begin
    in_ready = EI & (state == IDLE) & ~rst;
  end

  // Classify the presented word; GS and EO must disagree to be meaningful.
  always_comb begin
    accept       = in_valid & in_ready;
    word_legal   = accept &  GS & ~EO;
    word_empty   = accept & ~GS &  EO;
    word_illegal = accept & (GS == EO);
    decoded      = 8'h01 << Y;
    set_vec      = word_legal ? decoded : 8'h00;
  end

  // Next-state and next-output logic for the decode/hold FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no branch can
    // leave one unassigned and infer a latch.
    state_n    = state;
    hold_cnt_n = hold_cnt;
    o_n        = O;
    o_valid_n  = O_valid;

    unique case (state)
      IDLE: begin
        if (word_legal) begin
          state_n    = HOLD;
          o_n        = decoded;
          o_valid_n  = 1'b1;
          hold_cnt_n = HOLD_LOAD;
        end
      end

      HOLD: begin
        if (!EI) begin
          // Enable dropped: abandon the pulse immediately.
          state_n    = IDLE;
          o_n        = 8'h00;
          o_valid_n  = 1'b0;
          hold_cnt_n = 8'h00;
        end else if (hold_cnt != 8'h00) begin
          hold_cnt_n = hold_cnt - 8'h01;
        end else begin
          state_n   = IDLE;
          o_n       = 8'h00;
          o_valid_n = 1'b0;
        end
      end

      default: begin
        state_n    = IDLE;
        o_n        = 8'h00;
        o_valid_n  = 1'b0;
        hold_cnt_n = 8'h00;
      end
    endcase
  end

  // Side-band bookkeeping: set wins over clear on the same pend bit.
  always_comb begin
    pend_n      = (pend & ~clr) | set_vec;
    empty_cnt_n = empty_cnt;
    if (word_empty && empty_cnt != 8'hFF) begin
      empty_cnt_n = empty_cnt + 8'h01;
    end
    err_n = err | word_illegal;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= 8'h00;
      O         <= 8'h00;
      O_valid   <= 1'b0;
      pend      <= 8'h00;
      empty_cnt <= 8'h00;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      O         <= o_n;
      O_valid   <= o_valid_n;
      pend      <= pend_n;
      empty_cnt <= empty_cnt_n;
      err       <= err_n;
    end
  end

  // Structural invariants of the output pair.
  a_o_onehot0 : assert property (@(posedge clk) $onehot0(O));
  a_o_valid   : assert property (@(posedge clk) O_valid == (O != 8'h00));

endmodule

// File: tb/tb_decoder_38_seq.sv
// Bench for decoder_38_seq: two instances (HOLD_CYCLES=4 and 1) share one
// stimulus stream; a behavioural model predicts each edge, the prediction is
// queued at the rising edge and compared at the following falling edge.
module tb_decoder_38_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ei, iv, gs, eo;
  logic [2:0] y;
  logic [7:0] clr;

  logic       rdy4, ov4, err4, rdy1, ov1, err1;
  logic [7:0] o4, pend4, ec4, o1, pend1, ec1;

  int n_cmp = 0;
  int n_bad = 0;

  decoder_38_seq #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .EI(ei), .in_valid(iv), .Y(y), .GS(gs), .EO(eo),
    .clr(clr), .in_ready(rdy4), .O(o4), .O_valid(ov4), .pend(pend4),
    .empty_cnt(ec4), .err(err4)
  );

  decoder_38_seq #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .EI(ei), .in_valid(iv), .Y(y), .GS(gs), .EO(eo),
    .clr(clr), .in_ready(rdy1), .O(o1), .O_valid(ov1), .pend(pend1),
    .empty_cnt(ec1), .err(err1)
  );

  // Model state: 'left' is the number of cycles O still has to stay high,
  // including the current one.
  typedef struct packed {
    logic [7:0] o;
    logic       ov;
    logic [7:0] pend;
    logic [7:0] ecnt;
    logic       err;
    logic       busy;
    logic [8:0] left;
  } model_t;

  typedef struct packed {
    model_t m4;
    model_t m1;
  } pair_t;

  model_t m4, m1;
  pair_t  sb[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_next(model_t m, int h);
    model_t     n;
    logic [7:0] set;
    n   = m;
    set = 8'h00;
    if (rst) return '0;
    if (m.busy) begin
      if (!ei || m.left <= 9'd1) begin
        n.busy = 1'b0;
        n.o    = 8'h00;
        n.left = 9'd0;
      end else begin
        n.left = m.left - 9'd1;
      end
    end else if (iv && ei) begin
      if (gs && !eo) begin
        n.busy = 1'b1;
        n.o    = 8'(1 << y);
        n.left = 9'(h);
        set    = n.o;
      end else if (!gs && eo) begin
        if (m.ecnt != 8'd255) n.ecnt = m.ecnt + 8'd1;
      end else begin
        n.err = 1'b1;
      end
    end
    n.pend = (m.pend & ~clr) | set;
    n.ov   = (n.o != 8'h00);
    return n;
  endfunction

  function automatic logic exp_rdy(model_t m);
    return !rst && ei && !m.busy;
  endfunction

  // Predict at the rising edge from the inputs the DUTs are sampling.
  always @(posedge clk) begin
    m4 = model_next(m4, 4);
    m1 = model_next(m1, 1);
    sb.push_back('{m4: m4, m1: m1});
  end

  // Compare registered outputs half a cycle after the edge that made them.
  always @(negedge clk) begin
    pair_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("o4",     32'(o4),    32'(e.m4.o));
      check("ov4",    32'(ov4),   32'(e.m4.ov));
      check("pend4",  32'(pend4), 32'(e.m4.pend));
      check("ecnt4",  32'(ec4),   32'(e.m4.ecnt));
      check("err4",   32'(err4),  32'(e.m4.err));
      check("o1",     32'(o1),    32'(e.m1.o));
      check("ov1",    32'(ov1),   32'(e.m1.ov));
      check("pend1",  32'(pend1), 32'(e.m1.pend));
      check("ecnt1",  32'(ec1),   32'(e.m1.ecnt));
      check("err1",   32'(err1),  32'(e.m1.err));
    end
  end

  // One cycle: inputs already set at a falling edge; check the
  // combinational handshake, then advance to the next falling edge.
  task automatic step();
    #1;
    check("rdy4", 32'(rdy4), 32'(exp_rdy(m4)));
    check("rdy1", 32'(rdy1), 32'(exp_rdy(m1)));
    @(negedge clk);
  endtask

  task automatic word(input logic v, input logic [2:0] yy, input logic g,
                      input logic e);
    iv = v; y = yy; gs = g; eo = e;
  endtask

  initial begin
    rst = 1'b1; ei = 1'b0; clr = 8'h00;
    word(1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    step();
    check("rst_o4", 32'(o4), 32'h0);
    check("rst_pend4", 32'(pend4), 32'h0);

    rst = 1'b0; ei = 1'b1;
    step();

    // Basic decode of Y=5.
    word(1'b1, 3'd5, 1'b1, 1'b0);
    step();
    check("basic_o4", 32'(o4), 32'h20);
    check("basic_pend4", 32'(pend4), 32'h20);
    word(1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("basic_end_o4", 32'(o4), 32'h0);

    // Empty words: count saturates at 255.
    word(1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step();
    word(1'b0, 3'd0, 1'b0, 1'b0);
    step();
    check("sat_ecnt4", 32'(ec4), 32'd255);
    check("sat_ecnt1", 32'(ec1), 32'd255);

    // Illegal words: err sticks, nothing else moves.
    word(1'b1, 3'd2, 1'b1, 1'b1);
    step();
    word(1'b1, 3'd4, 1'b0, 1'b0);
    step();
    word(1'b0, 3'd0, 1'b0, 1'b0);
    step();
    check("ill_err4", 32'(err4), 32'h1);
    check("ill_pend4", 32'(pend4), 32'h20);
    check("ill_ecnt4", 32'(ec4), 32'd255);

    clr = 8'hFF;
    step();
    clr = 8'h00;

    // Abort: EI drops two cycles into HOLD.
    word(1'b1, 3'd3, 1'b1, 1'b0);
    step();
    word(1'b0, 3'd0, 1'b0, 1'b0);
    step();
    step();
    ei = 1'b0;
    step();
    check("abort_o4", 32'(o4), 32'h0);
    check("abort_pend4", 32'(pend4), 32'h08);
    word(1'b1, 3'd1, 1'b1, 1'b0);
    step();
    step();
    check("abort_ign_o4", 32'(o4), 32'h0);
    word(1'b0, 3'd0, 1'b0, 1'b0);
    ei = 1'b1;
    step();

    // Set/clear collision on pend[7].
    word(1'b1, 3'd7, 1'b1, 1'b0);
    clr = 8'h80;
    step();
    check("coll_pend4", 32'(pend4), 32'h88);
    word(1'b0, 3'd0, 1'b0, 1'b0);
    step();
    check("coll_clr_pend4", 32'(pend4), 32'h08);
    clr = 8'h00;
    for (int i = 0; i < 4; i++) step();

    // Single-cycle pulse sweep on the HOLD_CYCLES=1 instance.
    for (int i = 0; i < 8; i++) begin
      word(1'b1, 3'(i), 1'b1, 1'b0);
      step();
      check("sweep_o1", 32'(o1), 32'(1 << i));
      word(1'b0, 3'd0, 1'b0, 1'b0);
      step();
      check("sweep_off_o1", 32'(o1), 32'h0);
    end

    // Reset in the middle of a pulse.
    for (int i = 0; i < 4; i++) step();
    word(1'b1, 3'd6, 1'b1, 1'b0);
    step();
    check("mid_o1", 32'(o1), 32'h40);
    rst = 1'b1;
    step();
    check("mid_rst_o1", 32'(o1), 32'h0);
    check("mid_rst_o4", 32'(o4), 32'h0);
    check("mid_rst_pend4", 32'(pend4), 32'h0);
    rst = 1'b0;
    word(1'b0, 3'd0, 1'b0, 1'b0);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 250; i++) begin
      word(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      ei  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    word(1'b0, 3'd0, 1'b0, 1'b0);
    step();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decoder_38_seq.md
DECODER_38_SEQ -- requirements
Module: decoder_38_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, giving the number of cycles a decoded one-hot output is held; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port EI, input, 1, block enable, active-high.
REQ-005 SHALL have port in_valid, input, 1, code word present on Y/GS/EO.
REQ-006 SHALL have port Y, input, 3, encoded index of the highest-priority request.
REQ-007 SHALL have port GS, input, 1, group select: at least one request is active.
REQ-008 SHALL have port EO, input, 1, enable-out: encoder enabled with no request active.
REQ-009 SHALL have port clr, input, 8, per-bit clear for pend.
REQ-010 SHALL have port in_ready, output, 1, code word can be accepted this cycle.
REQ-011 SHALL have port O, output, 8, registered one-hot decoded output, active-high.
REQ-012 SHALL have port O_valid, output, 1, registered; high while O is nonzero.
REQ-013 SHALL have port pend, output, 8, registered sticky bitmap of decoded indices.
REQ-014 SHALL have port empty_cnt, output, 8, registered saturating count of accepted empty words.
REQ-015 SHALL have port err, output, 1, registered sticky flag for an illegal code word.

Function
REQ-016 SHALL implement the states IDLE and HOLD, plus an 8-bit down-counter hold_cnt.
REQ-017 SHALL drive in_ready = EI & (state == IDLE), combinationally.
REQ-018 SHALL accept a word only when in_valid & in_ready is high.
REQ-019 SHALL, on an accepted word with GS=1 and EO=0, set O to 1<<Y on the next edge, set O_valid=1, load hold_cnt with HOLD_CYCLES-1, set pend[Y], and move IDLE to HOLD.
REQ-020 SHALL, on an accepted word with GS=0 and EO=1, leave O at 0, increment empty_cnt, and stay in IDLE.
REQ-021 SHALL saturate empty_cnt at 255; no wrap-around.
REQ-022 SHALL treat an accepted word with GS=1 and EO=1 as illegal: set err, discard the word, leave O/pend/empty_cnt unchanged, and stay in IDLE.
REQ-023 SHALL treat an accepted word with GS=0 and EO=0 as illegal in the same way.
REQ-024 SHALL, in HOLD with hold_cnt != 0, hold O unchanged and decrement hold_cnt.
REQ-025 SHALL, in HOLD with hold_cnt == 0, clear O and O_valid on the next edge and return to IDLE.
REQ-026 SHALL keep O high for exactly HOLD_CYCLES cycles; with HOLD_CYCLES=1, O is high for exactly one cycle.
REQ-027 SHALL accept at most one word per HOLD_CYCLES+1 cycles.
REQ-028 SHALL make O visible one cycle after the accept edge (latency 1).
REQ-029 SHALL, if EI is low in HOLD, abort: clear O and O_valid and clear hold_cnt on the next edge, and return to IDLE; pend is retained.
REQ-030 SHALL ignore in_valid while EI is low; pend, empty_cnt and err still hold their values and clr still acts.
REQ-031 SHALL update pend as pend <= (pend & ~clr) | set_vec, where set_vec is the one-hot of an accepted legal word, else 0.
REQ-032 SHALL give set priority when set and clr hit the same bit in the same cycle, so the bit stays 1.
REQ-033 SHALL clear err only by reset.
REQ-034 SHALL always keep O either zero or one-hot.

Reset
REQ-035 SHALL, while rst is high at a clock edge, set state=IDLE, hold_cnt=0, O=8'h00, O_valid=0, pend=8'h00, empty_cnt=0 and err=0.
REQ-036 SHALL take rst over all other inputs, including mid-HOLD; O is 0 on the edge after rst is sampled.
REQ-037 SHALL force in_ready to 0 while rst is high.

Verification
REQ-038 Basic decode, HOLD_CYCLES=4, EI=1: accept Y=5, GS=1, EO=0 -> O=8'h20 for 4 cycles starting 1 cycle after accept; pend=8'h20; in_ready low for those 4 cycles, high on the 5th.
REQ-039 Empty and saturation: 300 accepted words with GS=0, EO=1 -> O stays 0; empty_cnt reads 255.
REQ-040 Illegal words: GS=1, EO=1, then GS=0, EO=0 -> err=1 and stays 1; O, pend and empty_cnt unchanged.
REQ-041 Abort: accept Y=3, drop EI 2 cycles into HOLD -> O=0 on the next edge; pend=8'h08 retained; in_ready stays 0 until EI returns.
REQ-042 Clear collision: accept Y=7 with clr=8'h80 on the same cycle -> pend[7]=1; clr=8'h80 the next cycle -> pend[7]=0.
REQ-043 Reset mid-HOLD with HOLD_CYCLES=1 sweep: all Y 0..7 back-to-back give single-cycle one-hot pulses; rst asserted during a pulse -> all outputs 0 on the next edge.
